// File: rtl/medidor_periodo.sv
// Period and high-time meter for a clock-like signal sampled as data in the clk domain.
// Results are in clk cycles and saturate at 2^W-1. A saturated capture sets a sticky overflow flag.
module medidor_periodo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_clk,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         valid,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == CNT_MAX) ? v : v + W'(1);
    endfunction

    function automatic logic is_sat(input logic [W-1:0] v);
        return (v == CNT_MAX);
    endfunction

    state_t         state_q, state_d;
    logic           in_d_q;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   period_q, period_d;
    logic [W-1:0]   high_time_q, high_time_d;
    logic           valid_q, valid_d;
    logic           overflow_q, overflow_d;
    logic           rise, fall;

    assign rise = in_clk & ~in_d_q;
    assign fall = ~in_clk & in_d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise in HIGH or a fall in LOW cannot happen, so the state simply holds on them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = HIGH;
            HIGH:    if (fall) state_d = LOW;
            LOW:     if (rise) state_d = HIGH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = rise ? W'(1) : sat_inc(cnt_q);
        hi_d        = hi_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        case (state_q)
            HIGH: begin
                if (fall) begin
                    hi_d = cnt_q;
                    if (is_sat(cnt_q)) overflow_d = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hi_q;
                    valid_d     = 1'b1;
                    if (is_sat(cnt_q)) overflow_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // in_d resets high so an input already high at release does not count as a rise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_d_q      <= 1'b1;
            cnt_q       <= '0;
            hi_q        <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            in_d_q      <= in_clk;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_medidor_periodo.sv
// Bench for medidor_periodo: W=16 and W=4 instances share stimulus, checked against a timestamp model.
module tb_medidor_periodo;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_clk;
    logic [15:0] period16, high16;
    logic        valid16, ovf16;
    logic [3:0]  period4, high4;
    logic        valid4, ovf4;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    int     vcnt16, vcnt4;

    always #5 clk = ~clk;

    medidor_periodo #(.W(16)) u_dut16 (
        .clk(clk), .reset(reset), .in_clk(in_clk),
        .period(period16), .high_time(high16), .valid(valid16), .overflow(ovf16)
    );

    medidor_periodo #(.W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_clk(in_clk),
        .period(period4), .high_time(high4), .valid(valid4), .overflow(ovf4)
    );

    // Reference: remembers when the measured period started and when the input fell,
    // and derives results from those timestamps, clipped to the counter maximum.
    typedef struct {
        longint maxv;
        int     phase;     // 0: no rise seen, 1: high part, 2: low part
        longint rise_t;
        longint hi_cap;
        logic   prev;
        longint per;
        longint high;
        logic   vld;
        logic   ovf;
    } mdl_t;

    mdl_t m[2];

    typedef struct {
        int   hi;
        int   lo;
        int   reps;
        int   per16;
        int   hi16;
        int   per4;
        int   hi4;
        logic ovf4;
    } vec_t;

    vec_t tbl[7];

    function automatic longint clip(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step(input int k, input logic inv, input logic rn);
        logic r, f;
        if (!rn) begin
            m[k].phase  = 0;
            m[k].prev   = 1'b1;
            m[k].hi_cap = 0;
            m[k].per    = 0;
            m[k].high   = 0;
            m[k].vld    = 1'b0;
            m[k].ovf    = 1'b0;
        end else begin
            r = inv & ~m[k].prev;
            f = ~inv & m[k].prev;
            m[k].vld = 1'b0;
            if (m[k].phase == 0 && r) begin
                m[k].phase  = 1;
                m[k].rise_t = cyc;
            end else if (m[k].phase == 1 && f) begin
                m[k].hi_cap = clip(cyc - m[k].rise_t, m[k].maxv);
                if (m[k].hi_cap == m[k].maxv) m[k].ovf = 1'b1;
                m[k].phase = 2;
            end else if (m[k].phase == 2 && r) begin
                m[k].per  = clip(cyc - m[k].rise_t, m[k].maxv);
                m[k].high = m[k].hi_cap;
                m[k].vld  = 1'b1;
                if (m[k].per == m[k].maxv) m[k].ovf = 1'b1;
                m[k].rise_t = cyc;
                m[k].phase  = 1;
            end
            m[k].prev = inv;
        end
    endtask

    task automatic step(input logic inv, input logic rn);
        @(negedge clk);
        in_clk = inv;
        reset  = rn;
        @(posedge clk);
        cyc++;
        model_step(0, inv, rn);
        model_step(1, inv, rn);
        #1;
        chk("valid16",  {31'd0, valid16}, {31'd0, m[0].vld});
        chk("period16", {16'd0, period16}, m[0].per[31:0]);
        chk("high16",   {16'd0, high16},   m[0].high[31:0]);
        chk("ovf16",    {31'd0, ovf16},    {31'd0, m[0].ovf});
        chk("valid4",   {31'd0, valid4},   {31'd0, m[1].vld});
        chk("period4",  {28'd0, period4},  m[1].per[31:0]);
        chk("high4",    {28'd0, high4},    m[1].high[31:0]);
        chk("ovf4",     {31'd0, ovf4},     {31'd0, m[1].ovf});
        if (valid16) vcnt16++;
        if (valid4)  vcnt4++;
    endtask

    task automatic do_reset(input logic lvl);
        step(lvl, 1'b0);
        step(lvl, 1'b0);
        vcnt16 = 0;
        vcnt4  = 0;
    endtask

    task automatic run_wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            repeat (hi) step(1'b1, 1'b1);
            repeat (lo) step(1'b0, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m[0].maxv = 65535;
        m[1].maxv = 15;
        for (int k = 0; k < 2; k++) begin
            m[k].phase = 0; m[k].rise_t = 0; m[k].hi_cap = 0; m[k].prev = 1'b1;
            m[k].per = 0; m[k].high = 0; m[k].vld = 1'b0; m[k].ovf = 1'b0;
        end
        in_clk = 1'b0;
        reset  = 1'b0;

        //        hi  lo  reps per16 hi16 per4 hi4 ovf4
        tbl[0] = '{2,  2,  5,   4,    2,   4,   2,  1'b0};
        tbl[1] = '{1,  1,  5,   2,    1,   2,   1,  1'b0};
        tbl[2] = '{3,  5,  4,   8,    3,   8,   3,  1'b0};
        tbl[3] = '{5,  3,  4,   8,    5,   8,   5,  1'b0};
        tbl[4] = '{20, 4,  2,   24,   20,  15,  15, 1'b1};
        tbl[5] = '{7,  9,  3,   16,   7,   15,  7,  1'b1};
        tbl[6] = '{1,  14, 3,   15,   1,   15,  1,  1'b1};

        do_reset(1'b0);
        chk("rst_period16", {16'd0, period16}, 32'd0);
        chk("rst_high16",   {16'd0, high16},   32'd0);
        chk("rst_valid16",  {31'd0, valid16},  32'd0);
        chk("rst_ovf16",    {31'd0, ovf16},    32'd0);
        chk("rst_period4",  {28'd0, period4},  32'd0);
        chk("rst_ovf4",     {31'd0, ovf4},     32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset(1'b0);
            step(1'b0, 1'b1);
            run_wave(tbl[i].hi, tbl[i].lo, tbl[i].reps);
            step(1'b1, 1'b1);
            chk("tbl_per16",    {16'd0, period16}, tbl[i].per16);
            chk("tbl_hi16",     {16'd0, high16},   tbl[i].hi16);
            chk("tbl_per4",     {28'd0, period4},  tbl[i].per4);
            chk("tbl_hi4",      {28'd0, high4},    tbl[i].hi4);
            chk("tbl_ovf16",    {31'd0, ovf16},    32'd0);
            chk("tbl_ovf4",     {31'd0, ovf4},     {31'd0, tbl[i].ovf4});
            chk("tbl_nvalid16", vcnt16, tbl[i].reps);
            chk("tbl_nvalid4",  vcnt4,  tbl[i].reps);
        end

        // Duty-cycle switch with a constant 8-cycle period.
        do_reset(1'b0);
        step(1'b0, 1'b1);
        run_wave(3, 5, 3);
        run_wave(5, 3, 3);
        step(1'b1, 1'b1);
        chk("sw_per16",    {16'd0, period16}, 32'd8);
        chk("sw_hi16",     {16'd0, high16},   32'd5);
        chk("sw_nvalid16", vcnt16, 6);

        // Overflow on W=4 stays set through normal periods afterwards.
        do_reset(1'b0);
        step(1'b0, 1'b1);
        run_wave(20, 4, 1);
        run_wave(2, 2, 3);
        step(1'b1, 1'b1);
        chk("sticky_per4", {28'd0, period4}, 32'd4);
        chk("sticky_hi4",  {28'd0, high4},   32'd2);
        chk("sticky_ovf4", {31'd0, ovf4},    32'd1);
        chk("sticky_ovf16", {31'd0, ovf16},  32'd0);

        // Input high through reset release, then a reset pulse mid-period.
        do_reset(1'b1);
        repeat (5) step(1'b1, 1'b1);
        chk("relhigh_nvalid", vcnt16, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("first_rise_nvalid", vcnt16, 0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("second_rise_nvalid", vcnt16, 1);
        chk("second_rise_per16",  {16'd0, period16}, 32'd4);
        chk("second_rise_hi16",   {16'd0, high16},   32'd2);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("midrst_per16",  {16'd0, period16}, 32'd0);
        chk("midrst_hi16",   {16'd0, high16},   32'd0);
        chk("midrst_valid4", {31'd0, valid4},   32'd0);
        vcnt16 = 0;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("postrst_nvalid", vcnt16, 0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("postrst_per16", {16'd0, period16}, 32'd3);
        chk("postrst_hi16",  {16'd0, high16},   32'd1);

        // Random waveforms, long constant stretches and occasional resets.
        do_reset(1'b0);
        for (int n = 0; n < 80; n++) begin
            int h, l;
            h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 40)) : int'($urandom_range(1, 20));
            l = int'($urandom_range(1, 20));
            run_wave(h, l, 1);
            if ($urandom_range(0, 14) == 0) step(1'($urandom_range(0, 1)), 1'b0);
        end
        step(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
